// File: rtl/move_command_queue.sv
// Parses SPI move messages into a 2**DEPTH_BITS ring buffer with a valid/ready head port.
// Define WORD_TIMEOUT_EN to abort half-received messages after TIMEOUT_CYCLES idle clocks.
module move_command_queue #(
  parameter int MOTOR_COUNT        = 1,
  parameter int DEPTH_BITS         = 2,
  parameter int MOVE_DURATION_BITS = 32,
  parameter int TIMEOUT_CYCLES     = 65535
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          word_received,
  input  logic [63:0]                   word_data,
  output logic [63:0]                   word_send_data,
  output logic                          move_valid,
  input  logic                          move_ready,
  output logic [MOTOR_COUNT-1:0]        move_dir,
  output logic [MOVE_DURATION_BITS-1:0] move_duration,
  output logic [64*MOTOR_COUNT-1:0]     move_increment,
  output logic [64*MOTOR_COUNT-1:0]     move_incrementincrement,
  output logic                          buffer_dtr,
  output logic [DEPTH_BITS:0]           queue_count,
  output logic                          overflow
);

  typedef enum logic [1:0] {
    IDLE,
    STEP_DUR,
    STEP_AXIS
  } state_e;

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int AXW   = (MOTOR_COUNT > 1) ? $clog2(MOTOR_COUNT) : 1;
  localparam int IW    = 64 * MOTOR_COUNT;
  localparam int DW    = MOVE_DURATION_BITS;
  localparam logic [AXW-1:0]      LAST_AX  = AXW'(MOTOR_COUNT - 1);
  localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);

  state_e state_q, state_d;
  logic [AXW-1:0] axis_q, axis_d;
  logic phase_q, phase_d;

  logic [MOTOR_COUNT-1:0] stg_dir_q, stg_dir_d;
  logic [DW-1:0] stg_dur_q, stg_dur_d;
  logic [IW-1:0] stg_inc_q, stg_inc_d;
  logic [IW-1:0] stg_ii_q, stg_ii_d;

  logic [DEPTH_BITS-1:0] wr_q, wr_d;
  logic [DEPTH_BITS-1:0] rd_q, rd_d;
  logic [DEPTH_BITS:0] cnt_q, cnt_d;
  logic [31:0] done_q, done_d;
  logic ovf_q, ovf_d;
  logic tmo_err_q, tmo_err_d;
  logic clr_q, clr_d;
  logic [63:0] send_q, send_d;

  logic [MOTOR_COUNT-1:0] mem_dir_q [DEPTH];
  logic [DW-1:0] mem_dur_q [DEPTH];
  logic [IW-1:0] mem_inc_q [DEPTH];
  logic [IW-1:0] mem_ii_q [DEPTH];

  logic commit, flush, stat_cmd, tmo_hit;
  logic full, pop, pop_eff, push;
  logic [63:0] status;

`ifdef WORD_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q != IDLE) && !word_received
                && (tmo_q == TMO_LAST);
  assign tmo_d = (state_q == IDLE || word_received)
               ? 32'd0 : tmo_q + 32'd1;

  always_ff @(posedge CLK) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit = 1'b0;
`endif

  assign move_valid = (cnt_q != '0);
  assign full       = (cnt_q == FULL_CNT);
  assign pop        = move_valid & move_ready;

  // Message parser
  always_comb begin
    state_d   = state_q;
    axis_d    = axis_q;
    phase_d   = phase_q;
    stg_dir_d = stg_dir_q;
    stg_dur_d = stg_dur_q;
    stg_inc_d = stg_inc_q;
    stg_ii_d  = stg_ii_q;
    commit    = 1'b0;
    flush     = 1'b0;
    stat_cmd  = 1'b0;
    if (word_received) begin
      unique case (state_q)
        IDLE: begin
          unique case (word_data[63:56])
            8'h01: begin
              stg_dir_d = word_data[MOTOR_COUNT-1:0];
              state_d   = STEP_DUR;
            end
            8'h02: stat_cmd = 1'b1;
            8'h03: flush    = 1'b1;
            default: ;
          endcase
        end
        STEP_DUR: begin
          stg_dur_d = word_data[DW-1:0];
          state_d   = STEP_AXIS;
          axis_d    = '0;
          phase_d   = 1'b0;
        end
        STEP_AXIS: begin
          if (!phase_q) begin
            stg_inc_d[64*int'(axis_q) +: 64] = word_data;
            phase_d = 1'b1;
          end else begin
            stg_ii_d[64*int'(axis_q) +: 64] = word_data;
            phase_d = 1'b0;
            if (axis_q == LAST_AX) begin
              commit  = 1'b1;
              state_d = IDLE;
              axis_d  = '0;
            end else begin
              axis_d = axis_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (tmo_hit) begin
      state_d = IDLE;
      axis_d  = '0;
      phase_d = 1'b0;
    end
  end

  // Ring buffer bookkeeping; flush overrides pop and commit
  always_comb begin
    pop_eff   = pop & ~flush;
    push      = commit & (~full | pop) & ~flush;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    tmo_err_d = tmo_err_q;
    clr_d     = stat_cmd;
    if (clr_q) begin
      ovf_d     = 1'b0;
      tmo_err_d = 1'b0;
    end
    if (tmo_hit) tmo_err_d = 1'b1;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (pop_eff) begin
        rd_d   = rd_q + 1'b1;
        done_d = done_q + 32'd1;
      end
      if (push) wr_d = wr_q + 1'b1;
      if (commit && !push) ovf_d = 1'b1;
      cnt_d = cnt_q
            + {{DEPTH_BITS{1'b0}}, push}
            - {{DEPTH_BITS{1'b0}}, pop_eff};
    end
    status                = '0;
    status[DEPTH_BITS:0]  = cnt_d;
    status[8]             = (cnt_d == FULL_CNT);
    status[9]             = (cnt_d == '0);
    status[10]            = ovf_d;
    status[11]            = tmo_err_d;
    status[47:16]         = done_d;
    send_d = word_received ? status : send_q;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      axis_q    <= '0;
      phase_q   <= 1'b0;
      stg_dir_q <= '0;
      stg_dur_q <= '0;
      stg_inc_q <= '0;
      stg_ii_q  <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      done_q    <= '0;
      ovf_q     <= 1'b0;
      tmo_err_q <= 1'b0;
      clr_q     <= 1'b0;
      send_q    <= '0;
    end else begin
      state_q   <= state_d;
      axis_q    <= axis_d;
      phase_q   <= phase_d;
      stg_dir_q <= stg_dir_d;
      stg_dur_q <= stg_dur_d;
      stg_inc_q <= stg_inc_d;
      stg_ii_q  <= stg_ii_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      tmo_err_q <= tmo_err_d;
      clr_q     <= clr_d;
      send_q    <= send_d;
    end
  end

  // Entry storage carries no reset; head outputs are masked while empty
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_dir_q[wr_q] <= stg_dir_d;
      mem_dur_q[wr_q] <= stg_dur_d;
      mem_inc_q[wr_q] <= stg_inc_d;
      mem_ii_q[wr_q]  <= stg_ii_d;
    end
  end

  assign move_dir       = move_valid ? mem_dir_q[rd_q] : '0;
  assign move_duration  = move_valid ? mem_dur_q[rd_q] : '0;
  assign move_increment = move_valid ? mem_inc_q[rd_q] : '0;
  assign move_incrementincrement =
    move_valid ? mem_ii_q[rd_q] : '0;

  assign word_send_data = send_q;
  assign buffer_dtr     = ~full;
  assign queue_count    = cnt_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_move_command_queue.sv
// Directed bench for move_command_queue: 2 axes, 4-entry queue.
// Build with WORD_TIMEOUT_EN defined to exercise the inter-word timeout.
module tb_move_command_queue;

  localparam int MC  = 2;
  localparam int DB  = 2;
  localparam int MDB = 32;

  logic CLK = 1'b0;
  logic reset;
  logic word_received;
  logic [63:0] word_data;
  logic [63:0] word_send_data;
  logic move_valid;
  logic move_ready;
  logic [MC-1:0] move_dir;
  logic [MDB-1:0] move_duration;
  logic [64*MC-1:0] move_increment;
  logic [64*MC-1:0] move_incrementincrement;
  logic buffer_dtr;
  logic [DB:0] queue_count;
  logic overflow;

  logic rdy_hold;
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] HDR_STEP = 64'h0100_0000_0000_0000;
  localparam logic [63:0] HDR_STAT = 64'h0200_0000_0000_0000;
  localparam logic [63:0] HDR_FLSH = 64'h0300_0000_0000_0000;

  move_command_queue #(
    .MOTOR_COUNT(MC),
    .DEPTH_BITS(DB),
    .MOVE_DURATION_BITS(MDB),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .word_received(word_received),
    .word_data(word_data),
    .word_send_data(word_send_data),
    .move_valid(move_valid),
    .move_ready(move_ready),
    .move_dir(move_dir),
    .move_duration(move_duration),
    .move_increment(move_increment),
    .move_incrementincrement(move_incrementincrement),
    .buffer_dtr(buffer_dtr),
    .queue_count(queue_count),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_word(input logic [63:0] w, input logic rdy);
    @(negedge CLK);
    word_received = 1'b1;
    word_data     = w;
    move_ready    = rdy;
    @(negedge CLK);
    word_received = 1'b0;
    move_ready    = rdy_hold;
  endtask

  // Move k: dir=k[1:0], dur=100+k, inc={k+10,k}, incinc={k+30,k+20}
  task automatic send_move(input int k, input logic last_rdy);
    logic [1:0] d;
    d = k[1:0];
    send_word(HDR_STEP | 64'(d), rdy_hold);
    send_word(64'(100 + k), rdy_hold);
    send_word(64'(k), rdy_hold);
    send_word(64'(k + 20), rdy_hold);
    send_word(64'(k + 10), rdy_hold);
    send_word(64'(k + 30), last_rdy | rdy_hold);
  endtask

  initial begin
    reset         = 1'b1;
    word_received = 1'b0;
    word_data     = '0;
    move_ready    = 1'b0;
    rdy_hold      = 1'b0;
    cycle(3);
    reset = 1'b0;
    cycle(1);

    chk("rst_valid", move_valid, 0);
    chk("rst_dtr", buffer_dtr, 1);
    chk("rst_count", queue_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_send", word_send_data, 0);

    // single coordinated move
    send_word(HDR_STEP | 64'h2, 1'b0);
    send_word(64'd1000, 1'b0);
    send_word(64'd5, 1'b0);
    send_word(64'd1, 1'b0);
    send_word(64'd7, 1'b0);
    chk("pre_commit_valid", move_valid, 0);
    send_word(64'd2, 1'b0);
    chk("a_valid", move_valid, 1);
    chk("a_dir", move_dir, 2'b10);
    chk("a_dur", move_duration, 1000);
    chk("a_inc", move_increment, {64'd7, 64'd5});
    chk("a_incinc", move_incrementincrement, {64'd2, 64'd1});
    chk("a_count", queue_count, 1);
    chk("a_status", word_send_data, 64'h1);

    // fill to 4, then overflow
    send_move(1, 1'b0);
    send_move(2, 1'b0);
    send_move(3, 1'b0);
    chk("full_count", queue_count, 4);
    chk("full_dtr", buffer_dtr, 0);
    chk("full_status", word_send_data, 64'h104);
    send_move(4, 1'b0);
    chk("drop_count", queue_count, 4);
    chk("drop_ovf", overflow, 1);
    chk("drop_status", word_send_data, 64'h504);
    chk("drop_head", move_duration, 1000);
    send_word(HDR_STAT, 1'b0);
    chk("stat1_reply", word_send_data, 64'h504);
    cycle(1);
    chk("stat_clr_ovf", overflow, 0);
    send_word(HDR_STAT, 1'b0);
    chk("stat2_reply", word_send_data, 64'h104);

    // commit into a full queue with a concurrent pop
    send_move(5, 1'b1);
    chk("pp_count", queue_count, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_status", word_send_data, 64'h1_0104);
    chk("pp_head", move_duration, 101);

    // single pop, then flush racing a pop
    move_ready = 1'b1;
    cycle(1);
    move_ready = 1'b0;
    chk("pop_count", queue_count, 3);
    chk("pop_head", move_duration, 102);
    send_word(HDR_FLSH, 1'b1);
    chk("fl_count", queue_count, 0);
    chk("fl_valid", move_valid, 0);
    chk("fl_status", word_send_data, 64'h2_0200);

    // reset in the middle of a message
    send_word(HDR_STEP | 64'h3, 1'b0);
    send_word(64'd999, 1'b0);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk("mid_rst_send", word_send_data, 0);
    send_move(21, 1'b0);
    chk("mid_rst_count", queue_count, 1);
    chk("mid_rst_dir", move_dir, 2'b01);
    chk("mid_rst_dur", move_duration, 121);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;

    // continuous popping across pointer wrap
    rdy_hold   = 1'b1;
    move_ready = 1'b1;
    for (int k = 10; k < 16; k++) begin
      send_move(k, 1'b1);
      chk("wrap_valid", move_valid, 1);
      chk("wrap_head", move_duration, 100 + k);
    end
    cycle(1);
    rdy_hold   = 1'b0;
    move_ready = 1'b0;
    chk("wrap_count", queue_count, 0);
    send_word(HDR_STAT, 1'b0);
    chk("wrap_done", word_send_data, 64'h6_0200);

`ifdef WORD_TIMEOUT_EN
    send_word(HDR_STEP | 64'h1, 1'b0);
    send_word(64'd777, 1'b0);
    cycle(20);
    send_word(HDR_STAT, 1'b0);
    chk("tmo_status", word_send_data, 64'h6_0A00);
    send_move(31, 1'b0);
    chk("tmo_next_count", queue_count, 1);
    chk("tmo_next_dur", move_duration, 131);
    chk("tmo_next_status", word_send_data, 64'h6_0001);
`else
    send_word(HDR_STEP | 64'h2, 1'b0);
    send_word(64'd130, 1'b0);
    cycle(20);
    send_word(64'd30, 1'b0);
    send_word(64'd50, 1'b0);
    send_word(64'd40, 1'b0);
    send_word(64'd60, 1'b0);
    chk("wait_count", queue_count, 1);
    chk("wait_dur", move_duration, 130);
    chk("wait_status", word_send_data, 64'h6_0001);
`endif
    send_word(HDR_FLSH, 1'b0);
    chk("end_flush_count", queue_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/move_command_queue.md
Name: move_command_queue

Overview:
Parametrised successor to the SPI command state machine's move-buffer logic. Parses 64-bit SPI words into coordinated multi-axis moves and holds them in a power-of-two ring buffer of configurable depth, replacing the fixed 2-entry toggle scheme. Drives a valid/ready dequeue port into the DDA FSM and returns a status word to the host on every transfer.

Parameters:
MOTOR_COUNT, 1, number of axes; per-axis increment and incrementincrement fields.
DEPTH_BITS, 2, queue depth = 2**DEPTH_BITS entries (1..6).
MOVE_DURATION_BITS, 32, width of the move duration field.
TIMEOUT_CYCLES, 65535, inter-word timeout in CLK cycles; used only with WORD_TIMEOUT_EN.

Ports:
CLK  in  1  system clock
reset  in  1  synchronous, active-high reset
word_received  in  1  one-cycle strobe, word_data valid (already in CLK domain)
word_data  in  64  received SPI word, little-endian; header in [63:56]
word_send_data  out  64  reply word for the next SPI transfer
move_valid  out  1  head entry valid
move_ready  in  1  DDA consumes head when move_valid & move_ready
move_dir  out  MOTOR_COUNT  head direction bits
move_duration  out  MOVE_DURATION_BITS  head duration
move_increment  out  64*MOTOR_COUNT  head increments, axis n at [64n+63:64n]
move_incrementincrement  out  64*MOTOR_COUNT  head incrementincrements, same packing
buffer_dtr  out  1  queue not full
queue_count  out  DEPTH_BITS+1  occupied entries
overflow  out  1  sticky: a complete move was dropped because the queue was full

Behaviour:
- Reset: all outputs 0 except buffer_dtr=1; read/write pointers, count, staging, completed counter and FSM cleared. A reset mid-message discards the staged move.
- FSM states: IDLE, STEP_DUR, STEP_AXIS. Commands: 8'h01 COORDINATED_STEP, 8'h02 QUEUE_STATUS, 8'h03 QUEUE_FLUSH; any other header is ignored and the FSM stays in IDLE.
- IDLE + header 8'h01: latch dir = word_data[MOTOR_COUNT-1:0] into staging, then go to STEP_DUR.
- STEP_DUR: latch duration = word_data[MOVE_DURATION_BITS-1:0], then go to STEP_AXIS with axis=0, phase=0.
- STEP_AXIS: phase 0 latches increment[axis]; phase 1 latches incrementincrement[axis], then axis+1. After incrementincrement of axis MOTOR_COUNT-1, commit and return to IDLE.
- Total message length is 2+2*MOTOR_COUNT words.
- Commit succeeds if count < 2**DEPTH_BITS, or if a pop occurs in the same cycle. On success the entry is written at the write pointer and the write pointer and count are updated. On failure the move is dropped and overflow is set.
- move_valid and the head fields update on the cycle after the committing strobe (1-cycle latency). Head fields are driven from storage at the read pointer. When move_valid=0 they are don't-care.
- Pop when move_valid & move_ready: read pointer +1 mod depth. The completed counter (32-bit) increments and wraps 0xFFFFFFFF -> 0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- QUEUE_FLUSH: pointers and count are zeroed in the same cycle and any concurrent pop or commit is ignored (flush wins). overflow is also cleared.
- Status word: [DEPTH_BITS:0] count, [8] full, [9] empty, [10] overflow, [11] timeout_err, [47:16] completed counter, others 0.
- word_send_data is loaded with the status word (values after that cycle's update) on every word_received strobe.
- QUEUE_STATUS: reply with the status word, then clear overflow and timeout_err on the following cycle. The reply retains the pre-clear flags.
- Pointers are DEPTH_BITS wide and wrap naturally; full = count == 2**DEPTH_BITS.

Optional Feature:
WORD_TIMEOUT_EN:
- Defined: a counter reloads on each strobe while the FSM is not in IDLE. If TIMEOUT_CYCLES pass with no strobe, the FSM returns to IDLE, the staged move is discarded and sticky timeout_err (status bit 11) is set.
- Undefined: the FSM waits indefinitely, status bit 11 reads 0, and TIMEOUT_CYCLES is unused.

Test Plan:
- MOTOR_COUNT=2, DEPTH_BITS=2: send 01 header with dir=2'b10, duration 1000, inc {5,7}, incinc {1,2} -> move_valid=1 one cycle after the 6th strobe, head fields match, queue_count=1.
- Push 4 moves with move_ready=0 -> buffer_dtr=0, count=4. A 5th complete move -> dropped, overflow=1, count stays 4. QUEUE_STATUS reply shows bit10=1; the next reply shows bit10=0.
- Queue full, then a 5th commit on the same cycle as a pop -> accepted, count stays 4, overflow=0.
- Push 6 moves while popping continuously -> pointers wrap, heads emerge in order, completed counter=6.
- Queue holds 3 moves; QUEUE_FLUSH in the same cycle as a pop -> count=0, move_valid=0, completed counter unchanged.
- WORD_TIMEOUT_EN, TIMEOUT_CYCLES=16: send header plus duration, then idle 20 cycles -> FSM in IDLE, timeout_err=1, count unchanged. A following 8'h03 header is parsed as a flush.
